// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 stream driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  localparam logic [6:0] SHOW_IDX = 7'h7F;

  localparam int ST_BUSY = 0;
  localparam int ST_PEND = 1;
  localparam int ST_ACK  = 2;

endpackage

// File: rtl/ws2812_frame_buffer.sv
// Double-banked frame store: 256x8, one write port, one registered read port.
module ws2812_frame_buffer (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_re,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [256];
  logic [7:0] r_rdata;

  // Read data holds between reads so the serialiser can index it for a whole byte.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ws2812_stream_driver.sv
// CPU-fed WS2812 serialiser: toggle-strobed byte writes into a back bank,
// show command swaps banks and streams the front bank with exact bit timing.
module ws2812_stream_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 40,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 3000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] led_adress,
  input  logic [7:0] led_data,
  output logic [7:0] led_control,
  output logic       led_dout
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int CW     = $clog2(LATCH_CYC + BIT_CYC);
  localparam logic [6:0]    LAST_IDX  = 7'(NBYTES - 1);
  localparam logic [CW-1:0] HI1_END   = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] HI0_END   = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] LO1_END   = CW'(BIT_CYC - T1H_CYC - 1);
  localparam logic [CW-1:0] LO0_END   = CW'(BIT_CYC - T0H_CYC - 1);
  localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYC - 1);

  state_t        r_state, w_next;
  logic          r_prev_tgl, r_bank_sel, r_pend, r_busy, r_dout;
  logic [6:0]    r_idx;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_cyc;
  logic [7:0]    w_rdata, w_ctrl;
  logic          w_evt, w_wr, w_show, w_bit, w_last_byte;
  logic          w_hi_done, w_lo_done, w_latch_done, w_restart;

  assign w_evt        = led_adress[7] != r_prev_tgl;
  assign w_wr         = w_evt && (led_adress[6:0] < 7'(NBYTES));
  assign w_show       = w_evt && (led_adress[6:0] == SHOW_IDX);
  assign w_bit        = w_rdata[r_bit];
  assign w_last_byte  = r_idx == LAST_IDX;
  assign w_hi_done    = r_cyc == (w_bit ? HI1_END : HI0_END);
  assign w_lo_done    = r_cyc == (w_bit ? LO1_END : LO0_END);
  assign w_latch_done = r_cyc == LATCH_END;
  assign w_restart    = (r_state == S_IDLE && w_show) ||
                        (r_state == S_LATCH && w_latch_done && (r_pend || w_show));

  // Writes use the pre-swap bank_sel, so a write racing a swap lands in the old back bank.
  ws2812_frame_buffer u_fb (
    .i_clk   (clk_clk),
    .i_we    (w_wr && !reset_reset),
    .i_waddr ({~r_bank_sel, led_adress[6:0]}),
    .i_wdata (led_data),
    .i_re    (r_state == S_LOAD),
    .i_raddr ({r_bank_sel, r_idx}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_show) w_next = S_LOAD;
      S_LOAD:  w_next = S_HIGH;
      S_HIGH:  if (w_hi_done) w_next = S_LOW;
      S_LOW:   if (w_lo_done)
                 w_next = (r_bit != 3'd0) ? S_HIGH : (w_last_byte ? S_LATCH : S_LOAD);
      S_LATCH: if (w_latch_done) w_next = (r_pend || w_show) ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_prev_tgl <= led_adress[7];
      r_bank_sel <= 1'b0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_dout     <= 1'b0;
      r_idx      <= '0;
      r_bit      <= '0;
      r_cyc      <= '0;
    end else begin
      r_prev_tgl <= led_adress[7];
      r_busy     <= r_state != S_IDLE;
      r_dout     <= r_state == S_HIGH;
      r_cyc      <= r_cyc + CW'(1);
      if (w_restart) begin
        r_bank_sel <= ~r_bank_sel;
        r_idx      <= '0;
        r_pend     <= 1'b0;
      end else if (w_show && r_state != S_IDLE) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        S_LOAD: begin
          r_bit <= 3'd7;
          r_cyc <= '0;
        end
        // Before a byte boundary the LOW phase starts at 1, donating a cycle to LOAD.
        S_HIGH: if (w_hi_done) r_cyc <= (r_bit == 3'd0 && !w_last_byte) ? CW'(1) : '0;
        S_LOW: if (w_lo_done) begin
          r_cyc <= '0;
          if (r_bit != 3'd0)     r_bit <= r_bit - 3'd1;
          else if (!w_last_byte) r_idx <= r_idx + 7'd1;
        end
        S_LATCH: if (w_latch_done) r_cyc <= '0;
        default: r_cyc <= '0;
      endcase
    end
  end

  always_comb begin
    w_ctrl          = '0;
    w_ctrl[ST_BUSY] = r_busy;
    w_ctrl[ST_PEND] = r_pend;
    w_ctrl[ST_ACK]  = r_prev_tgl;
  end

  assign led_control = w_ctrl;
  assign led_dout    = r_dout;

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Directed bench for ws2812_stream_driver with a one-LED strip.
module tb_ws2812_stream_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led_adress = 8'h00;
  logic [7:0] led_data = 8'h00;
  logic [7:0] led_control;
  logic       led_dout;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic tgl = 1'b0;

  int hi_len [24];
  int per_len [24];
  int tail_len, rise_cyc, busy_fall, cap_to;
  logic [7:0] exp_b [3];

  ws2812_stream_driver #(
    .NUM_LEDS(1), .T0H_CYC(20), .T1H_CYC(40), .BIT_CYC(63), .LATCH_CYC(3000)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .led_adress  (led_adress),
    .led_data    (led_data),
    .led_control (led_control),
    .led_dout    (led_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic cpu_write(input logic [6:0] idx, input logic [7:0] d);
    @(negedge clk);
    led_data = d;
    @(negedge clk);
    tgl = ~tgl;
    led_adress = {tgl, idx};
  endtask

  task automatic write_frame();
    for (int i = 0; i < 3; i++) cpu_write(7'(i), exp_b[i]);
  endtask

  // Measures 24 high/period lengths; ends on busy falling or on the next frame's rise.
  task automatic capture_frame();
    int h, l;
    cap_to = 0;
    busy_fall = -1;
    l = 0;
    while (led_dout !== 1'b1 && l < 100) begin @(negedge clk); l++; end
    if (led_dout !== 1'b1) begin cap_to = 1; return; end
    rise_cyc = cyc_cnt;
    for (int b = 0; b < 24; b++) begin
      h = 0;
      while (led_dout === 1'b1 && h < 100) begin h++; @(negedge clk); end
      l = 0;
      while (led_dout === 1'b0 && l < 4000) begin
        if (led_control[0] === 1'b0) begin busy_fall = cyc_cnt; break; end
        l++;
        @(negedge clk);
      end
      hi_len[b]  = h;
      per_len[b] = h + l;
    end
    tail_len = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tgl = 1'b1;
    led_adress = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (led_control !== 8'h04) begin errors++; $display("FAIL reset_ctrl: got %h exp 04", led_control); end
    checks++; if (led_dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b exp 0", led_dout); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (led_control !== 8'h04) begin errors++; $display("FAIL post_reset_ctrl: got %h exp 04", led_control); end
    checks++; if (led_dout !== 1'b0) begin errors++; $display("FAIL post_reset_dout: got %b exp 0", led_dout); end
  endtask

  task automatic test_frame();
    int eh;
    exp_b[0] = 8'hFF; exp_b[1] = 8'h00; exp_b[2] = 8'hA5;
    write_frame();
    @(negedge clk);
    checks++; if (led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL write_ack: got %h exp %h", led_control, {5'b0, tgl, 2'b00}); end
    cpu_write(7'h7F, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++; if (led_dout !== 1'b0 || led_control[0] !== 1'b1) begin errors++; $display("FAIL show_k1: dout %b busy %b exp 0/1", led_dout, led_control[0]); end
    @(negedge clk);
    checks++; if (led_dout !== 1'b1 || led_control[0] !== 1'b1) begin errors++; $display("FAIL show_k2: dout %b busy %b exp 1/1", led_dout, led_control[0]); end
    capture_frame();
    checks++; if (cap_to != 0) begin errors++; $display("FAIL frame_rise: no rising edge seen"); end
    for (int b = 0; b < 24; b++) begin
      eh = exp_b[b / 8][7 - (b % 8)] ? 40 : 20;
      checks++; if (hi_len[b] != eh) begin errors++; $display("FAIL frame_hi bit %0d: got %0d exp %0d", b, hi_len[b], eh); end
      if (b < 23) begin
        checks++; if (per_len[b] != 63) begin errors++; $display("FAIL frame_period bit %0d: got %0d exp 63", b, per_len[b]); end
      end
    end
    checks++; if (tail_len != 63 - 40 + 3000) begin errors++; $display("FAIL frame_tail: got %0d exp %0d", tail_len, 3023); end
    checks++; if (busy_fall - rise_cyc != 24 * 63 + 3000) begin errors++; $display("FAIL frame_busy_len: got %0d exp %0d", busy_fall - rise_cyc, 4512); end
    @(negedge clk);
    checks++; if (led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL frame_idle_ctrl: got %h exp %h", led_control, {5'b0, tgl, 2'b00}); end
  endtask

  task automatic test_invalid_idx();
    cpu_write(7'h50, 8'h77);
    @(negedge clk);
    checks++; if (led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL inval_50_ack: got %h exp %h", led_control, {5'b0, tgl, 2'b00}); end
    cpu_write(7'd3, 8'h55);
    @(negedge clk);
    checks++; if (led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL inval_03_ack: got %h exp %h", led_control, {5'b0, tgl, 2'b00}); end
    repeat (20) @(negedge clk);
    checks++; if (led_dout !== 1'b0 || led_control[0] !== 1'b0) begin errors++; $display("FAIL inval_no_tx: dout %b busy %b exp 0/0", led_dout, led_control[0]); end
  endtask

  task automatic test_pending();
    int eh;
    exp_b[0] = 8'h0F; exp_b[1] = 8'hF0; exp_b[2] = 8'h3C;
    write_frame();
    cpu_write(7'h7F, 8'h00);
    fork
      capture_frame();
      begin
        repeat (300) @(negedge clk);
        cpu_write(7'd0, 8'h81);
        cpu_write(7'd1, 8'h42);
        cpu_write(7'd2, 8'h18);
        cpu_write(7'h7F, 8'h00);
        cpu_write(7'h7F, 8'h00);
        @(negedge clk);
        checks++; if (led_control[1] !== 1'b1 || led_control[0] !== 1'b1) begin errors++; $display("FAIL pend_set: pend %b busy %b exp 1/1", led_control[1], led_control[0]); end
      end
    join
    checks++; if (cap_to != 0) begin errors++; $display("FAIL pendA_rise: no rising edge seen"); end
    for (int b = 0; b < 24; b++) begin
      eh = exp_b[b / 8][7 - (b % 8)] ? 40 : 20;
      checks++; if (hi_len[b] != eh) begin errors++; $display("FAIL pendA_hi bit %0d: got %0d exp %0d", b, hi_len[b], eh); end
    end
    checks++; if (busy_fall != -1) begin errors++; $display("FAIL pendA_busy_gap: busy fell at %0d", busy_fall); end
    checks++; if (tail_len < 63 - 20 + 3000) begin errors++; $display("FAIL pendA_latch: got %0d exp >= %0d", tail_len, 3043); end
    checks++; if (led_control[1] !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b exp 0", led_control[1]); end
    exp_b[0] = 8'h81; exp_b[1] = 8'h42; exp_b[2] = 8'h18;
    capture_frame();
    checks++; if (cap_to != 0) begin errors++; $display("FAIL pendB_rise: no rising edge seen"); end
    for (int b = 0; b < 24; b++) begin
      eh = exp_b[b / 8][7 - (b % 8)] ? 40 : 20;
      checks++; if (hi_len[b] != eh) begin errors++; $display("FAIL pendB_hi bit %0d: got %0d exp %0d", b, hi_len[b], eh); end
    end
    checks++; if (busy_fall - rise_cyc != 24 * 63 + 3000) begin errors++; $display("FAIL pendB_busy_len: got %0d exp 4512", busy_fall - rise_cyc); end
    repeat (200) @(negedge clk);
    checks++; if (led_dout !== 1'b0 || led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL pend_no_third: dout %b ctrl %h", led_dout, led_control); end
  endtask

  task automatic test_reset_mid();
    int eh, w;
    exp_b[0] = 8'hE7; exp_b[1] = 8'h24; exp_b[2] = 8'h5A;
    write_frame();
    cpu_write(7'h7F, 8'h00);
    w = 0;
    while (led_dout !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    checks++; if (led_dout !== 1'b1) begin errors++; $display("FAIL rmid_rise: got %b exp 1", led_dout); end
    repeat (10 * 63 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (led_dout !== 1'b0 || led_control !== {5'b0, tgl, 2'b00}) begin errors++; $display("FAIL rmid_abort: dout %b ctrl %h exp 0/%h", led_dout, led_control, {5'b0, tgl, 2'b00}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_b[0] = 8'hC3; exp_b[1] = 8'h11; exp_b[2] = 8'h99;
    write_frame();
    cpu_write(7'h7F, 8'h00);
    capture_frame();
    checks++; if (cap_to != 0) begin errors++; $display("FAIL rmid_refr_rise: no rising edge seen"); end
    for (int b = 0; b < 24; b++) begin
      eh = exp_b[b / 8][7 - (b % 8)] ? 40 : 20;
      checks++; if (hi_len[b] != eh) begin errors++; $display("FAIL rmid_hi bit %0d: got %0d exp %0d", b, hi_len[b], eh); end
    end
    checks++; if (busy_fall - rise_cyc != 24 * 63 + 3000) begin errors++; $display("FAIL rmid_busy_len: got %0d exp 4512", busy_fall - rise_cyc); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_invalid_idx();
    test_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
